mem_wb_stage: RTL and testbench

Memory-access stage of the 5-stage pipeline, fused with the MEM/WB pipeline register. It performs data-memory loads and stores on an on-chip word memory with a configurable access latency. While an access is in progress it raises a stall to freeze upstream stages. It registers WB_EN, MEM_R_EN, memData, aluRes and Dest for the write-back stage, which selects memData when MEM_R_EN=1 and aluRes otherwise.

---
 rtl/mem_wb_stage.sv | 124 ++++++++++++
 tb/tb_mem_wb_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage fused with the MEM/WB pipeline register.
// Word memory with a fixed multi-cycle access latency; stalls upstream until the access completes.
module mem_wb_stage #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] aluRes_in,
    input  logic [31:0] Val_Rm,
    input  logic [3:0]  Dest_in,
    output logic        stall,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic [31:0] memData,
    output logic [31:0] aluRes,
    output logic [3:0]  Dest
);

    localparam int unsigned Depth   = 1 << ADDR_W;
    localparam logic [3:0]  LastCnt = 4'(LATENCY - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_op;
    logic              complete;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;
    logic [31:0]       mem_q [Depth];

    logic              wb_en_q;
    logic              mem_r_en_q;
    logic [31:0]       mem_data_q;
    logic [31:0]       alu_res_q;
    logic [3:0]        dest_q;

    // Byte-offset bits and bits above the word index are intentionally ignored (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aluRes_in[31:ADDR_W+2], aluRes_in[1:0]};

    assign mem_op   = MEM_R_EN_in | MEM_W_EN_in;
    assign addr     = aluRes_in[ADDR_W+1:2];
    assign stall    = mem_op & (cnt_q != LastCnt);
    assign complete = ~stall;
    assign rdata    = mem_q[addr];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!complete) begin
                    state_d = StWait;
                    cnt_d   = 4'd1;
                end
            end
            StWait: begin
                if (complete) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store commits only on the completion edge, so an aborted access never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && MEM_W_EN_in) begin
            mem_q[addr] <= Val_Rm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_data_q <= '0;
            alu_res_q  <= '0;
            dest_q     <= '0;
        end else if (complete) begin
            wb_en_q    <= WB_EN_in;
            mem_r_en_q <= MEM_R_EN_in;
            mem_data_q <= rdata;
            alu_res_q  <= aluRes_in;
            dest_q     <= Dest_in;
        end else begin
            // Bubble: control bits cleared, data fields hold.
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
        end
    end

    assign WB_EN    = wb_en_q;
    assign MEM_R_EN = mem_r_en_q;
    assign memData  = mem_data_q;
    assign aluRes   = alu_res_q;
    assign Dest     = dest_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: two instances (LATENCY 2 and 4), scoreboard of expected outputs.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic [31:0] md;
        logic [31:0] alu;
        logic [3:0]  dest;
    } out_t;

    logic        clk = 1'b0;
    logic        rst2, rst4;
    logic        wb_in, rd_in, wr_in;
    logic [31:0] alu_in, val_in;
    logic [3:0]  dest_in;

    logic        stall2, wb2, mr2, stall4, wb4, mr4;
    logic [31:0] md2, alu2, md4, alu4;
    logic [3:0]  dest2, dest4;

    logic        sel4;
    out_t        obs;
    logic        stall_obs;

    int          checks   = 0;
    int          failures = 0;
    out_t        exp_q[$];
    out_t        last;
    logic [31:0] mmem [64];

    always #5 clk = ~clk;

    mem_wb_stage #(.LATENCY(2), .ADDR_W(6)) u_dut2 (
        .clk(clk), .rst_n(rst2), .WB_EN_in(wb_in), .MEM_R_EN_in(rd_in), .MEM_W_EN_in(wr_in),
        .aluRes_in(alu_in), .Val_Rm(val_in), .Dest_in(dest_in), .stall(stall2), .WB_EN(wb2),
        .MEM_R_EN(mr2), .memData(md2), .aluRes(alu2), .Dest(dest2)
    );

    mem_wb_stage #(.LATENCY(4), .ADDR_W(6)) u_dut4 (
        .clk(clk), .rst_n(rst4), .WB_EN_in(wb_in), .MEM_R_EN_in(rd_in), .MEM_W_EN_in(wr_in),
        .aluRes_in(alu_in), .Val_Rm(val_in), .Dest_in(dest_in), .stall(stall4), .WB_EN(wb4),
        .MEM_R_EN(mr4), .memData(md4), .aluRes(alu4), .Dest(dest4)
    );

    always_comb begin
        obs       = sel4 ? {wb4, mr4, md4, alu4, dest4} : {wb2, mr2, md2, alu2, dest2};
        stall_obs = sel4 ? stall4 : stall2;
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic compare_out(input string tag);
        out_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".WB_EN"}, {31'd0, obs.wb}, {31'd0, e.wb});
            check({tag, ".MEM_R_EN"}, {31'd0, obs.mr}, {31'd0, e.mr});
            check({tag, ".memData"}, obs.md, e.md);
            check({tag, ".aluRes"}, obs.alu, e.alu);
            check({tag, ".Dest"}, {28'd0, obs.dest}, {28'd0, e.dest});
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mmem[i] = '0;
        last = '0;
    endtask

    // Called at a falling edge; presents one instruction and holds it until completion.
    task automatic do_op(input string tag, input int lat, input logic wb, input logic rd,
                         input logic wr, input logic [31:0] alu, input logic [31:0] val,
                         input logic [3:0] dest);
        int   n;
        int   a;
        out_t e;
        wb_in   = wb;
        rd_in   = rd;
        wr_in   = wr;
        alu_in  = alu;
        val_in  = val;
        dest_in = dest;
        n = (rd | wr) ? lat : 1;
        a = int'(alu[7:2]);
        for (int c = 0; c < n; c++) begin
            #1;
            check({tag, ".stall"}, {31'd0, stall_obs}, {31'd0, (c != n - 1)});
            if (c == n - 1) begin
                e.wb   = wb;
                e.mr   = rd;
                e.md   = mmem[a];
                e.alu  = alu;
                e.dest = dest;
                if (wr) mmem[a] = val;
            end else begin
                e    = last;
                e.wb = 1'b0;
                e.mr = 1'b0;
            end
            last = e;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            compare_out(tag);
            @(negedge clk);
        end
    endtask

    initial begin
        sel4    = 1'b0;
        rst2    = 1'b0;
        rst4    = 1'b0;
        wb_in   = 1'b0;
        rd_in   = 1'b0;
        wr_in   = 1'b0;
        alu_in  = '0;
        val_in  = '0;
        dest_in = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst2 = 1'b1;

        #1;
        exp_q.push_back('0);
        compare_out("init");
        check("init.stall", {31'd0, stall_obs}, 32'd0);
        @(negedge clk);

        do_op("alu_pass", 2, 1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h0, 4'd5);

        // Asynchronous reset in the middle of the low phase, no clock edge in between.
        #3;
        rst2 = 1'b0;
        #1;
        exp_q.push_back('0);
        compare_out("async_rst");
        clear_model();
        @(negedge clk);
        rst2 = 1'b1;

        do_op("load_after_rst", 2, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'd1);
        do_op("store_404", 2, 1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'd0);
        do_op("load_wrap", 2, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'd7);
        do_op("store_c", 2, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h0000_0055, 4'd0);
        do_op("rw_both", 2, 1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_0066, 4'd3);
        do_op("load_c", 2, 1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 4'd4);
        do_op("alu_after", 2, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 4'd9);

        sel4 = 1'b1;
        clear_model();
        rst4 = 1'b1;
        do_op("l4_store", 4, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_CAFE, 4'd0);
        do_op("l4_load", 4, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'd2);

        // Store to 0x20 aborted by reset in its second cycle.
        wb_in   = 1'b0;
        rd_in   = 1'b0;
        wr_in   = 1'b1;
        alu_in  = 32'h0000_0020;
        val_in  = 32'h0000_1234;
        dest_in = 4'd0;
        #1;
        check("abort.stall0", {31'd0, stall_obs}, 32'd1);
        e_push_bubble();
        @(posedge clk);
        #1;
        compare_out("abort.bubble");
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        exp_q.push_back('0);
        compare_out("abort.rst");
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        do_op("abort.load", 4, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'd6);
        do_op("l4_alu", 4, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0, 4'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic e_push_bubble();
        out_t e;
        e    = last;
        e.wb = 1'b0;
        e.mr = 1'b0;
        last = e;
        exp_q.push_back(e);
    endtask

endmodule
